// File: rtl/cpu_control_unit_if.sv
// ---------------------------------------------------------------------------
// cpu_control_unit_if
//   Bundles the control unit's opcode input, run level and every datapath
//   strobe/select it drives, so the control unit and the datapath (or a
//   bench) connect through one port.
//
//   run          run level, only looked at while the sequencer is idle
//   ircu         opcode field of the instruction register
//   a_select     A mux: 0 = external input A, 1 = answer register
//   b_select     B mux: 0 = external input B, 1 = answer register
//   a_load       load register A
//   b_load       load register B
//   ans_load     load the answer register from the ALU
//   ir_load      load the instruction register from the ROM output
//   pc_load      load the PC from the next-address mux
//   jsm          next-address source: 00 increment, 01 IR address, 10 mode
//   select_mode  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR
//   halt         high while the sequencer is halted
//   state        current sequencer state (debug)
//
//   master : the control unit (drives strobes, receives run/ircu)
//   slave  : the datapath side
// ---------------------------------------------------------------------------
interface cpu_control_unit_if #(
  parameter int OPW  = 4,
  parameter int SELW = 2
);
  logic            run;
  logic [OPW-1:0]  ircu;
  logic            a_select;
  logic            b_select;
  logic            a_load;
  logic            b_load;
  logic            ans_load;
  logic            ir_load;
  logic            pc_load;
  logic [SELW-1:0] jsm;
  logic [SELW-1:0] select_mode;
  logic            halt;
  logic [2:0]      state;

  modport master (
    input  run, ircu,
    output a_select, b_select, a_load, b_load, ans_load, ir_load, pc_load,
           jsm, select_mode, halt, state
  );

  modport slave (
    output run, ircu,
    input  a_select, b_select, a_load, b_load, ans_load, ir_load, pc_load,
           jsm, select_mode, halt, state
  );
endinterface

// File: rtl/cpu_control_unit.sv
// ---------------------------------------------------------------------------
// cpu_control_unit
//   Moore sequencer for the accumulator-style CPU datapath. Each instruction
//   takes four cycles: FETCH (ROM registers word[PC]), LOAD (IR captures it),
//   DECODE (opcode now valid) and EXEC (one cycle of opcode strobes plus the
//   PC update). Opcode 1111 halts the machine until reset.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, returns the sequencer to IDLE
//   bus    cpu_control_unit_if.master: run/ircu in, all datapath strobes,
//          selects, ALU mode, PC source, halt flag and debug state out
// ---------------------------------------------------------------------------
module cpu_control_unit #(
  parameter int OPW  = 4,
  parameter int SELW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_LDA  = OPW'(1);
  localparam logic [OPW-1:0] OP_LDB  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_MVA  = OPW'(7);
  localparam logic [OPW-1:0] OP_MVB  = OPW'(8);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(9);
  localparam logic [OPW-1:0] OP_JMPM = OPW'(10);
  localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};

  localparam logic [SELW-1:0] JSM_IR   = SELW'(1);
  localparam logic [SELW-1:0] JSM_MODE = SELW'(2);

  localparam logic [SELW-1:0] ALU_ADD = SELW'(0);
  localparam logic [SELW-1:0] ALU_SUB = SELW'(1);
  localparam logic [SELW-1:0] ALU_AND = SELW'(2);
  localparam logic [SELW-1:0] ALU_OR  = SELW'(3);

  state_t          state_q;
  state_t          state_d;
  logic            a_select;
  logic            b_select;
  logic            a_load;
  logic            b_load;
  logic            ans_load;
  logic            ir_load;
  logic            pc_load;
  logic [SELW-1:0] jsm;
  logic [SELW-1:0] select_mode;
  logic            halt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the state register only (plus the opcode in
  // EXEC), so an asynchronous reset silences every strobe immediately.
  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    a_select    = 1'b0;
    b_select    = 1'b0;
    a_load      = 1'b0;
    b_load      = 1'b0;
    ans_load    = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    jsm         = '0;
    select_mode = '0;
    halt        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        ir_load = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = (bus.ircu == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        pc_load = 1'b1;
        state_d = FETCH;
        case (bus.ircu)
          OP_LDA:  a_load = 1'b1;
          OP_LDB:  b_load = 1'b1;
          OP_ADD:  begin ans_load = 1'b1; select_mode = ALU_ADD; end
          OP_SUB:  begin ans_load = 1'b1; select_mode = ALU_SUB; end
          OP_AND:  begin ans_load = 1'b1; select_mode = ALU_AND; end
          OP_OR:   begin ans_load = 1'b1; select_mode = ALU_OR;  end
          OP_MVA:  begin a_load = 1'b1; a_select = 1'b1; end
          OP_MVB:  begin b_load = 1'b1; b_select = 1'b1; end
          OP_JMP:  jsm = JSM_IR;
          OP_JMPM: jsm = JSM_MODE;
          // NOP and the reserved opcodes only advance the PC.
          default: ;
        endcase
      end
      HALT: begin
        // Terminal: only reset leaves this state.
        halt = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.a_select    = a_select;
  assign bus.b_select    = b_select;
  assign bus.a_load      = a_load;
  assign bus.b_load      = b_load;
  assign bus.ans_load    = ans_load;
  assign bus.ir_load     = ir_load;
  assign bus.pc_load     = pc_load;
  assign bus.jsm         = jsm;
  assign bus.select_mode = select_mode;
  assign bus.halt        = halt;
  assign bus.state       = state_q;

endmodule
